// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU and EXT ports.
// Build option DMEM_ARB_RR_EN: round-robin between simultaneous requests.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU,
        S_EXT,
        S_EXT_LOCKED
    } state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic          mem_own_ext;
    logic          locked;
    logic          burst_full;
    logic          lk_idle;
    logic          lk_busy;
    logic          both_req;
    logic          cpu_win;
    logic          ext_win;

`ifdef DMEM_ARB_RR_EN
    logic rr_last;
`endif

    assign locked     = (state == S_EXT_LOCKED);
    assign burst_full = (burst_cnt == BMAX);
    assign lk_idle    = !reset && locked && !ext_req;
    assign lk_busy    = !reset && locked && ext_req;
    assign both_req   = !reset && !locked && cpu_req && ext_req;

    always_comb begin
        cpu_win = 1'b0;
        ext_win = 1'b0;
        unique case (1'b1)
            reset: ;
            lk_idle: cpu_win = cpu_req;
            lk_busy: begin
                cpu_win = cpu_req && burst_full;
                ext_win = !(cpu_req && burst_full);
            end
            both_req: begin
`ifdef DMEM_ARB_RR_EN
                cpu_win = rr_last;
                ext_win = !rr_last;
`else
                cpu_win = 1'b1;
`endif
            end
            default: begin
                cpu_win = cpu_req;
                ext_win = ext_req;
            end
        endcase
    end

    assign cpu_gnt   = cpu_win;
    assign ext_gnt   = ext_win;
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            burst_cnt   <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_own_ext <= 1'b0;
            cpu_rvalid  <= 1'b0;
            ext_rvalid  <= 1'b0;
        end else begin
            // read owner follows the command one stage down the pipe
            cpu_rvalid <= mem_en && !mem_we && !mem_own_ext;
            ext_rvalid <= mem_en && !mem_we && mem_own_ext;
            mem_en     <= cpu_win || ext_win;
            mem_we     <= (cpu_win && cpu_we) || (ext_win && ext_we);
            if (cpu_win) begin
                mem_addr    <= cpu_addr;
                mem_wdata   <= cpu_wdata;
                mem_own_ext <= 1'b0;
            end else if (ext_win) begin
                mem_addr    <= ext_addr;
                mem_wdata   <= ext_wdata;
                mem_own_ext <= 1'b1;
            end
            unique case (1'b1)
                lk_idle: begin
                    state     <= S_IDLE;
                    burst_cnt <= '0;
                end
                lk_busy && cpu_win: burst_cnt <= '0;
                lk_busy && ext_win && ext_lock: begin
                    if (!burst_full) burst_cnt <= burst_cnt + BW'(1);
                end
                lk_busy && ext_win && !ext_lock: begin
                    state     <= S_EXT;
                    burst_cnt <= '0;
                end
                !locked && ext_win && ext_lock: begin
                    state     <= S_EXT_LOCKED;
                    burst_cnt <= BW'(1);
                end
                !locked && ext_win && !ext_lock: state <= S_EXT;
                !locked && cpu_win: state <= S_CPU;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // 0 = CPU owned the last beat, 1 = EXT
    always_ff @(posedge clk) begin
        if (reset) rr_last <= 1'b0;
        else if (cpu_win) rr_last <= 1'b0;
        else if (ext_win) rr_last <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter
// against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int MW = AW + DW + 2;
    localparam int RW = DW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic          ext_lock = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // single-port RAM, one cycle read latency
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct packed {
        int            due;
        logic          ext;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rdq[$];
    logic [DW-1:0] ref_mem [256];
    bit            m_locked = 1'b0;
    int            m_streak = 0;
    bit            m_last_ext = 1'b0;
    int            cyc = 0;
    logic          e_en = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [1:0] predict();
        if (reset) return 2'b00;
        if (m_locked && !ext_req) return {cpu_req, 1'b0};
        if (m_locked) return (cpu_req && m_streak >= MB) ? 2'b10 : 2'b01;
        if (cpu_req && ext_req) begin
`ifdef DMEM_ARB_RR_EN
            return m_last_ext ? 2'b10 : 2'b01;
`else
            return 2'b10;
`endif
        end
        return {cpu_req, ext_req};
    endfunction

    task automatic model_edge(input logic [1:0] g);
        cyc++;
        if (reset) begin
            rdq.delete();
            m_locked = 1'b0;
            m_streak = 0;
            m_last_ext = 1'b0;
            e_en = 1'b0;
            e_we = 1'b0;
            e_addr = '0;
            e_wdata = '0;
            return;
        end
        e_en = (g != 2'b00);
        e_we = 1'b0;
        if (g[1]) begin
            e_we = cpu_we;
            e_addr = cpu_addr;
            e_wdata = cpu_wdata;
            m_last_ext = 1'b0;
        end else if (g[0]) begin
            e_we = ext_we;
            e_addr = ext_addr;
            e_wdata = ext_wdata;
            m_last_ext = 1'b1;
        end
        if (e_en && e_we) ref_mem[e_addr] = e_wdata;
        if (e_en && !e_we)
            rdq.push_back('{due: cyc + 1, ext: !g[1],
                            data: ref_mem[e_addr]});
        if (m_locked) begin
            if (!ext_req) begin
                m_locked = 1'b0;
                m_streak = 0;
            end else if (g[1]) begin
                m_streak = 0;
            end else if (ext_lock) begin
                m_streak = (m_streak < MB) ? m_streak + 1 : MB;
            end else begin
                m_locked = 1'b0;
                m_streak = 0;
            end
        end else if (g[0] && ext_lock) begin
            m_locked = 1'b1;
            m_streak = 1;
        end
    endtask

    // one clock: grant sampled before the edge, registered outputs after
    task automatic run_cycle(output logic [1:0] go, output logic [1:0] ge,
                             output logic [MW-1:0] mo,
                             output logic [MW-1:0] me,
                             output logic [RW-1:0] ro,
                             output logic [RW-1:0] re);
        rd_t it;
        logic [DW-1:0] od;
        #2;
        go = {cpu_gnt, ext_gnt};
        ge = predict();
        @(posedge clk);
        model_edge(ge);
        #1;
        mo = mem_en ? {1'b1, mem_we, mem_addr, mem_wdata} : '0;
        me = e_en ? {1'b1, e_we, e_addr, e_wdata} : '0;
        od = cpu_rvalid ? cpu_rdata : (ext_rvalid ? ext_rdata : '0);
        ro = {cpu_rvalid, ext_rvalid, od};
        re = '0;
        while (rdq.size() > 0 && rdq[0].due < cyc) it = rdq.pop_front();
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            it = rdq.pop_front();
            re = {!it.ext, it.ext, it.data};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        bit cp, ep;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h01;
        ext_wdata = '0; ext_lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 2;
            if (go !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_gnt got=%b want=00", go);
            end
            if ({mem_en, mem_we, mem_addr, mem_wdata,
                 cpu_rvalid, ext_rvalid} !== '0) begin
                n_bad++;
                $display("FAIL reset_out got=%b want=0",
                         {mem_en, mem_we, mem_addr, mem_wdata,
                          cpu_rvalid, ext_rvalid});
            end
        end
        reset = 1'b0;
        cp = 1'b1;
        ep = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_req = cp;
            ext_req = ep;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL rst_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL rst_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL rst_rd i=%0d got=%h want=%h", i, ro, re);
            end
`ifndef DMEM_ARB_RR_EN
            if (i == 0) begin
                n_cmp++;
                if (go !== 2'b10) begin
                    n_bad++;
                    $display("FAIL first_gnt got=%b want=10", go);
                end
            end
`endif
            if (ge[1]) cp = 1'b0;
            if (ge[0]) ep = 1'b0;
        end
    endtask

    task automatic test_cpu_read();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        ext_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_req = (i == 0) || (i == 2);
            cpu_we = (i == 0);
            cpu_addr = 8'h10;
            cpu_wdata = (i == 0) ? 8'hA5 : 8'h00;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL rd_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL rd_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL rd_rv i=%0d got=%h want=%h", i, ro, re);
            end
            if (i == 2) begin
                n_cmp++;
                if (mo !== {2'b10, 8'h10, 8'h00}) begin
                    n_bad++;
                    $display("FAIL rd_cmd got=%h want=21000", mo);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (ro !== {2'b10, 8'hA5}) begin
                    n_bad++;
                    $display("FAIL rd_data got=%h want=2a5", ro);
                end
            end
        end
    endtask

    task automatic test_raw();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        bit cp, ep, seen;
        logic [DW-1:0] got_d;
        cp = 1'b1; ep = 1'b1; seen = 1'b0; got_d = '0;
        for (int i = 0; i < 6; i++) begin
            cpu_req = cp; cpu_we = 1'b1;
            cpu_addr = 8'h20; cpu_wdata = 8'hA5;
            ext_req = ep; ext_we = 1'b0; ext_lock = 1'b0;
            ext_addr = 8'h20; ext_wdata = '0;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL raw_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL raw_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL raw_rv i=%0d got=%h want=%h", i, ro, re);
            end
            if (ro[DW]) begin
                seen = 1'b1;
                got_d = ro[DW-1:0];
            end
            if (ge[1]) cp = 1'b0;
            if (ge[0]) ep = 1'b0;
        end
`ifndef DMEM_ARB_RR_EN
        n_cmp++;
        if ({seen, got_d} !== {1'b1, 8'hA5}) begin
            n_bad++;
            $display("FAIL raw_data got=%b/%h want=1/a5", seen, got_d);
        end
`endif
    endtask

    task automatic test_burst_lock();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        int ext_i, cpu_n, n_g;
        logic [9:0] order;
        ext_i = 0; cpu_n = 0; n_g = 0; order = '0;
        for (int t = 0; t < 40; t++) begin
            ext_req = (ext_i < 8); ext_we = 1'b1; ext_lock = 1'b1;
            ext_addr = AW'(8'h30 + ext_i);
            ext_wdata = DW'(8'hC0 + ext_i);
            cpu_req = (ext_i >= 1) && (cpu_n < 2);
            cpu_we = 1'b0; cpu_addr = 8'h30; cpu_wdata = '0;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL bl_gnt t=%0d got=%b want=%b", t, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL bl_mem t=%0d got=%h want=%h", t, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL bl_rv t=%0d got=%h want=%h", t, ro, re);
            end
            if (go != 2'b00) begin
                order = {order[8:0], go[0]};
                n_g++;
            end
            if (ge[0]) ext_i++;
            if (ge[1]) cpu_n++;
            if (ext_i >= 8 && cpu_n >= 2 && t > 14) break;
        end
        n_cmp++;
        if (n_g != 10 || order !== 10'b11110_11110) begin
            n_bad++;
            $display("FAIL bl_order got=%b n=%0d want=1111011110 n=10",
                     order, n_g);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        int rv_seen;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            reset = (i == 1);
            cpu_req = (i == 0) || (i == 5);
            cpu_we = (i == 5);
            cpu_addr = (i == 5) ? 8'h40 : 8'h10;
            cpu_wdata = 8'h5A;
            ext_req = (i == 5); ext_we = 1'b1; ext_lock = 1'b0;
            ext_addr = 8'h41; ext_wdata = 8'h3C;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL mr_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL mr_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL mr_rv i=%0d got=%h want=%h", i, ro, re);
            end
            if (i >= 1 && i <= 4 && ro[RW-1:RW-2] != 2'b00) rv_seen++;
            if (i == 1) begin
                n_cmp++;
                if (mem_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mr_en got=%b want=0", mem_en);
                end
            end
        end
        reset = 1'b0;
        n_cmp++;
        if (rv_seen != 0) begin
            n_bad++;
            $display("FAIL mr_norv got=%0d want=0", rv_seen);
        end
        cpu_req = 1'b0;
        ext_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ext_req = (i == 0) && !ge[0];
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp++;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL mr_tail i=%0d got=%b want=%b", i, go, ge);
            end
        end
    endtask

    task automatic test_contend();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        int n_ext, n_alt;
        logic [1:0] prev;
        n_ext = 0; n_alt = 0; prev = 2'b00;
        cpu_we = 1'b1; ext_we = 1'b1; ext_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_req = 1'b1; ext_req = 1'b1;
            cpu_addr = AW'(8'h50 + i); cpu_wdata = DW'(i);
            ext_addr = AW'(8'h60 + i); ext_wdata = DW'(8'h80 + i);
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 2;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL ct_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL ct_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (go[0]) n_ext++;
            if (i > 0 && go != prev) n_alt++;
            prev = go;
        end
        n_cmp++;
`ifdef DMEM_ARB_RR_EN
        if (n_ext != 3 || n_alt != 5) begin
            n_bad++;
            $display("FAIL ct_rr ext=%0d alt=%0d want=3/5", n_ext, n_alt);
        end
`else
        if (n_ext != 0) begin
            n_bad++;
            $display("FAIL ct_fixed ext=%0d want=0", n_ext);
        end
`endif
        cpu_req = 1'b0;
        ext_req = 1'b0;
        run_cycle(go, ge, mo, me, ro, re);
    endtask

    task automatic test_random();
        logic [1:0] go, ge;
        logic [MW-1:0] mo, me;
        logic [RW-1:0] ro, re;
        bit cp, ep;
        cp = 1'b0; ep = 1'b0;
        ext_req = 1'b0;
        for (int a = 0; a < 16; a++) begin
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = AW'(a); cpu_wdata = DW'($urandom);
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp++;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL fill_gnt a=%0d got=%b want=%b", a, go, ge);
            end
        end
        for (int i = 0; i < 420; i++) begin
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 15));
                cpu_wdata = DW'($urandom);
            end
            if (!ep && $urandom_range(0, 3) != 0) begin
                ep = 1'b1;
                ext_we = 1'($urandom_range(0, 1));
                ext_addr = AW'($urandom_range(0, 15));
                ext_wdata = DW'($urandom);
            end
            if (i >= 410) begin
                cp = 1'b0;
                ep = 1'b0;
            end
            ext_lock = ($urandom_range(0, 3) != 0);
            reset = (i < 400) && ($urandom_range(0, 63) == 0);
            cpu_req = cp;
            ext_req = ep;
            run_cycle(go, ge, mo, me, ro, re);
            n_cmp += 3;
            if (go !== ge) begin
                n_bad++;
                $display("FAIL rnd_gnt i=%0d got=%b want=%b", i, go, ge);
            end
            if (mo !== me) begin
                n_bad++;
                $display("FAIL rnd_mem i=%0d got=%h want=%h", i, mo, me);
            end
            if (ro !== re) begin
                n_bad++;
                $display("FAIL rnd_rv i=%0d got=%h want=%h", i, ro, re);
            end
            if (ge[1]) cp = 1'b0;
            if (ge[0]) ep = 1'b0;
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_raw();
        test_burst_lock();
        test_reset_mid_read();
        test_contend();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
